// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
// Module      : button_event
// Description : Converts a debounced, clk-synchronous button level into
//               single-cycle press / release / short / long / repeat events
//               plus a held level for the display mode and digit-step logic.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event #(
  parameter int LONG_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  input  logic enable,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  // Counter values that fire a threshold on the current high sample.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             prev_q;
  logic             rise;
  logic             press_next;
  logic             release_next;
  logic             short_next;
  logic             long_next;
  logic             repeat_next;

  // A press starts only on a fresh 0->1 edge, so a level held through reset
  // or through a disabled period is ignored until released.
  assign rise = button_in & ~prev_q;

  // Next-state, counter and event decode; release always beats a threshold.
  always_comb begin
    state_next   = state;
    count_next   = count;
    press_next   = 1'b0;
    release_next = 1'b0;
    short_next   = 1'b0;
    long_next    = 1'b0;
    repeat_next  = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state)
        IDLE: begin
          count_next = '0;
          if (rise) begin
            state_next = PRESSED;
            count_next = CNT_ONE;
            press_next = 1'b1;
          end
        end
        PRESSED: begin
          if (!button_in) begin
            state_next   = IDLE;
            count_next   = '0;
            release_next = 1'b1;
            short_next   = 1'b1;
          end else if (count == LONG_LAST) begin
            state_next = LONG;
            count_next = '0;
            long_next  = 1'b1;
          end else begin
            count_next = count + CNT_ONE;
          end
        end
        LONG: begin
          if (!button_in) begin
            state_next   = IDLE;
            count_next   = '0;
            release_next = 1'b1;
          end else if (count == REPEAT_LAST) begin
            count_next  = '0;
            repeat_next = 1'b1;
          end else begin
            count_next = count + CNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  // State, counter, edge history and registered event outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      prev_q        <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      prev_q        <= button_in;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      short_press   <= short_next;
      long_press    <= long_next;
      repeat_pulse  <= repeat_next;
      held          <= (state_next != IDLE);
    end
  end

endmodule
`default_nettype wire

// File: doc/button_event.md
Name: button_event

Overview:
- Sits directly downstream of the debouncer. Consumes its clean, clk-synchronous debounced level.
- Turns the level into single-cycle control events for the 7-segment display logic: press, release, short press, long press and auto-repeat while held.
- Feeds the mode/digit-step logic, so one physical press produces exactly one event.

Parameters:
LONG_CYCLES, 25000000, cycles held before press is long (0.5 s at 50 MHz); must be >= 2
REPEAT_CYCLES, 5000000, cycles between repeat pulses after long press (100 ms at 50 MHz); must be >= 1
CNT_W, 25, hold counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES)

Ports:
clk  input  1  system clock, single domain
reset  input  1  synchronous, active-high reset
button_in  input  1  debounced button level from debouncer (already synchronous to clk)
enable  input  1  high = events generated; low = block held idle
press_pulse  output  1  one-cycle pulse on press
release_pulse  output  1  one-cycle pulse on release
short_press  output  1  one-cycle pulse on release of a press shorter than LONG_CYCLES
long_press  output  1  one-cycle pulse when hold reaches LONG_CYCLES
repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while long-held
held  output  1  level: a press is in progress (state != IDLE)

Behaviour:
- All outputs registered. On reset: all outputs 0, state IDLE, counter 0, prev_q = 1.
- prev_q = 1 at reset means a button held through reset yields no press until released and pressed again.
- prev_q follows button_in every cycle, including while enable is low. Rise = button_in & ~prev_q.
- Timing: let k be the first cycle sampling button_in = 1 with prev_q = 0, and r the first later cycle sampling 0.
- press_pulse is high in cycle k+1 only.
- States:
  - IDLE: on rise -> PRESSED, counter = 1, press_pulse.
  - PRESSED, button_in = 1: counter increments. When counter == LONG_CYCLES-1 on a high sample (cycle k+LONG_CYCLES-1) -> LONG, counter = 0; long_press high in cycle k+LONG_CYCLES.
  - PRESSED, button_in = 0: -> IDLE; short_press and release_pulse both high in cycle r+1.
  - LONG, button_in = 1: counter increments. When counter == REPEAT_CYCLES-1 -> counter = 0, repeat_pulse. Repeat pulses fall in cycles k+LONG_CYCLES+m*REPEAT_CYCLES, m >= 1.
  - LONG, button_in = 0: -> IDLE; release_pulse only, no short_press and no repeat in that cycle.
- Simultaneous threshold and release: release wins. A low sample never produces long_press or repeat_pulse, so a press exactly LONG_CYCLES-1 samples long is short.
- held is high from cycle k+1 through cycle r; low in r+1.
- At most one of long_press, repeat_pulse and short_press is high in any cycle. press_pulse and release_pulse are never high together.
- enable low:
  - State forced to IDLE and counter to 0 on the next edge; all pulses and held are 0 from that edge.
  - No release/short event is emitted for an aborted press.
  - After enable returns high, a button still held produces nothing until a fresh rise.
- Reset mid-press: immediate return to reset values on that edge; no pulses emitted.
- Counter never wraps: it is cleared at each threshold and at each IDLE entry.

Test Plan:
- Use LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4 for all scenarios.
- Short press: reset, then button_in high for 3 cycles from cycle k -> press_pulse at k+1, held k+1..k+3, short_press and release_pulse at k+4; no long_press.
- Long press with repeat: button_in high 20 cycles from k -> press_pulse k+1, long_press k+8, repeat_pulse k+12, k+16, k+20; release_pulse k+21, no short_press.
- Boundary: hold 7 samples -> short_press at k+8, no long_press. Hold 8 samples -> long_press at k+8, then release_pulse at k+9, no short_press.
- Held through reset: button_in = 1 during reset and for 10 cycles after -> no outputs. Release, then press again -> normal press_pulse.
- Enable abort: start long hold, drop enable at k+5 for 3 cycles while still held -> held and all pulses 0 from k+6; no events after enable returns until release followed by a new press.
- Bouncy input: pulses of 1-cycle high / 1-cycle low x5 -> exactly 5 press_pulse, 5 short_press, 5 release_pulse, alternating correctly.
